// File: rtl/xif_copro_arbiter.sv
// Shares one X-interface coprocessor between two CPU requesters.
// A single offloaded instruction is tracked from issue through commit to result.
module xif_copro_arbiter #(
  parameter int ID_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CID           = ID_WIDTH + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  // CPU issue
  input  logic [1:0]                    cpu_issue_valid_i,
  output logic [1:0]                    cpu_issue_ready_o,
  input  logic [1:0][31:0]              cpu_issue_instr_i,
  input  logic [1:0][ID_WIDTH-1:0]      cpu_issue_id_i,
  input  logic [1:0][1:0][31:0]         cpu_issue_rs_i,
  input  logic [1:0][1:0]               cpu_issue_rs_valid_i,
  output logic [1:0]                    cpu_issue_accept_o,
  output logic [1:0]                    cpu_issue_writeback_o,
  // CPU commit / result
  input  logic [1:0]                    cpu_commit_valid_i,
  input  logic [1:0][ID_WIDTH-1:0]      cpu_commit_id_i,
  input  logic [1:0]                    cpu_commit_kill_i,
  output logic [1:0]                    cpu_result_valid_o,
  input  logic [1:0]                    cpu_result_ready_i,
  output logic [ID_WIDTH-1:0]           cpu_result_id_o,
  output logic [31:0]                   cpu_result_data_o,
  output logic [4:0]                    cpu_result_rd_o,
  output logic                          cpu_result_we_o,
  // Coprocessor
  output logic                          co_issue_valid_o,
  input  logic                          co_issue_ready_i,
  output logic [31:0]                   co_issue_instr_o,
  output logic [CID-1:0]                co_issue_id_o,
  output logic [1:0][31:0]              co_issue_rs_o,
  output logic [1:0]                    co_issue_rs_valid_o,
  input  logic                          co_issue_accept_i,
  input  logic                          co_issue_writeback_i,
  output logic                          co_commit_valid_o,
  output logic [CID-1:0]                co_commit_id_o,
  output logic                          co_commit_kill_o,
  input  logic                          co_result_valid_i,
  output logic                          co_result_ready_o,
  input  logic [CID-1:0]                co_result_id_i,
  input  logic [31:0]                   co_result_data_i,
  input  logic [4:0]                    co_result_rd_i,
  input  logic                          co_result_we_i,
  // Status
  output logic                          busy_o,
  output logic                          owner_o,
  output logic                          timeout_o,
  input  logic                          timeout_clr_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_COMMIT, WAIT_RESULT} state_e;

  // Counter is wide enough that saturation sits strictly above the limit,
  // so the limit is crossed exactly once per wait.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               rr_q, rr_d;
  logic               wb_q, wb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               timeout_q, timeout_d;

  logic issue_hs, commit_en, res_hs, to_set;

  always_comb begin
    cpu_issue_ready_o     = '0;
    cpu_issue_accept_o    = '0;
    cpu_issue_writeback_o = '0;
    cpu_result_valid_o    = '0;
    co_issue_valid_o      = 1'b0;
    co_result_ready_o     = 1'b0;
    co_issue_instr_o      = cpu_issue_instr_i[owner_q];
    co_issue_id_o         = {owner_q, cpu_issue_id_i[owner_q]};
    co_issue_rs_o         = cpu_issue_rs_i[owner_q];
    co_issue_rs_valid_o   = cpu_issue_rs_valid_i[owner_q];
    co_commit_id_o        = {owner_q, cpu_commit_id_i[owner_q]};
    co_commit_kill_o      = cpu_commit_kill_i[owner_q];
    cpu_result_id_o       = co_result_id_i[ID_WIDTH-1:0];
    cpu_result_data_o     = co_result_data_i;
    cpu_result_rd_o       = co_result_rd_i;
    cpu_result_we_o       = co_result_we_i;

    issue_hs = (state_q == ISSUE) && cpu_issue_valid_i[owner_q] && co_issue_ready_i;
    res_hs   = (state_q == WAIT_RESULT) && co_result_valid_i && cpu_result_ready_i[owner_q];

    if (state_q == ISSUE) begin
      co_issue_valid_o                 = cpu_issue_valid_i[owner_q];
      cpu_issue_ready_o[owner_q]       = co_issue_ready_i;
      cpu_issue_accept_o[owner_q]      = co_issue_accept_i;
      cpu_issue_writeback_o[owner_q]   = co_issue_writeback_i;
    end
    if (state_q == WAIT_RESULT) begin
      cpu_result_valid_o[owner_q] = co_result_valid_i;
      co_result_ready_o           = cpu_result_ready_i[owner_q];
    end

    // Commit may ride along with the accepting issue handshake.
    commit_en         = (state_q == WAIT_COMMIT) || (issue_hs && co_issue_accept_i);
    co_commit_valid_o = commit_en && cpu_commit_valid_i[owner_q];
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    wb_d      = wb_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    to_set    = 1'b0;

    case (state_q)
      IDLE: begin
        if (|cpu_issue_valid_i) begin
          owner_d = (cpu_issue_valid_i == 2'b11) ? rr_q : cpu_issue_valid_i[1];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_hs) begin
          if (!co_issue_accept_i) begin
            state_d = IDLE;
          end else begin
            wb_d = co_issue_writeback_i;
            if (!co_commit_valid_o)
              state_d = WAIT_COMMIT;
            else if (!co_commit_kill_o && co_issue_writeback_i)
              state_d = WAIT_RESULT;
            else
              state_d = IDLE;
          end
        end
      end
      WAIT_COMMIT: begin
        if (co_commit_valid_o)
          state_d = (!co_commit_kill_o && wb_q) ? WAIT_RESULT : IDLE;
      end
      WAIT_RESULT: begin
        if (res_hs) begin
          state_d = IDLE;
        end else begin
          cnt_d  = cnt_inc;
          to_set = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_LIM);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == WAIT_RESULT && state_q != WAIT_RESULT) cnt_d = '0;
    if (state_d == IDLE && state_q != IDLE) rr_d = ~owner_q;

    if (to_set)             timeout_d = 1'b1;
    else if (timeout_clr_i) timeout_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_q      <= 1'b0;
      wb_q      <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      wb_q      <= wb_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign owner_o   = owner_q;
  assign timeout_o = timeout_q;

endmodule

// File: doc/xif_copro_arbiter.md
XIF_COPRO_ARBITER -- requirements
Module: xif_copro_arbiter

Interface
REQ-001 SHALL have parameters: ID_WIDTH, default 4, CPU instruction ID width; TIMEOUT_CYCLES, default 1024, result-wait limit (0 = disabled).
REQ-002 SHALL have ports: clk_i  in  1  sole clock; rst_ni  in  1  reset, synchronous, active-low.
REQ-003 SHALL have CPU issue ports, index r in {0,1}: cpu_issue_valid_i  in  2; cpu_issue_ready_o  out  2; cpu_issue_instr_i  in  2x32; cpu_issue_id_i  in  2xID_WIDTH; cpu_issue_rs_i  in  2x2x32; cpu_issue_rs_valid_i  in  2x2; cpu_issue_accept_o  out  2; cpu_issue_writeback_o  out  2.
REQ-004 SHALL have CPU commit/result ports: cpu_commit_valid_i  in  2; cpu_commit_id_i  in  2xID_WIDTH; cpu_commit_kill_i  in  2; cpu_result_valid_o  out  2; cpu_result_ready_i  in  2; cpu_result_id_o  out  ID_WIDTH; cpu_result_data_o  out  32; cpu_result_rd_o  out  5; cpu_result_we_o  out  1.
REQ-005 SHALL have coprocessor ports with CID = ID_WIDTH+1: co_issue_valid_o  out  1; co_issue_ready_i  in  1; co_issue_instr_o  out  32; co_issue_id_o  out  CID; co_issue_rs_o  out  2x32; co_issue_rs_valid_o  out  2; co_issue_accept_i  in  1; co_issue_writeback_i  in  1; co_commit_valid_o  out  1; co_commit_id_o  out  CID; co_commit_kill_o  out  1; co_result_valid_i  in  1; co_result_ready_o  out  1; co_result_id_i  in  CID; co_result_data_i  in  32; co_result_rd_i  in  5; co_result_we_i  in  1.
REQ-006 SHALL have status ports: busy_o  out  1  state != IDLE; owner_o  out  1  granted requester; timeout_o  out  1  sticky timeout flag; timeout_clr_i  in  1  clears timeout_o.

Function
REQ-007 SHALL implement FSM IDLE, ISSUE, WAIT_COMMIT, WAIT_RESULT; exactly one offloaded instruction in flight.
REQ-008 IDLE: if any cpu_issue_valid_i set, SHALL register owner (sole requester, or rr_q if both) and go ISSUE next cycle; all cpu_issue_ready_o = 0 in IDLE.
REQ-009 ISSUE: co_issue_valid_o = cpu_issue_valid_i[owner]; instr/rs/rs_valid from owner; co_issue_id_o = {owner, cpu_issue_id_i[owner]}.
REQ-010 ISSUE: cpu_issue_ready_o[owner] = co_issue_ready_i, accept/writeback forwarded to owner only; non-owner ready/accept/writeback = 0.
REQ-011 Issue handshake with accept=0 SHALL go IDLE; with accept=1 SHALL latch writeback into wb_q and go WAIT_COMMIT.
REQ-012 Commit: co_commit_valid_o = cpu_commit_valid_i[owner] in WAIT_COMMIT, and in ISSUE during the accepted-handshake cycle; co_commit_id_o = {owner, cpu_commit_id_i[owner]}; kill forwarded; non-owner commits dropped.
REQ-013 On forwarded commit: kill=1 -> IDLE; kill=0 and wb_q=1 -> WAIT_RESULT; kill=0 and wb_q=0 -> IDLE.
REQ-014 WAIT_RESULT: cpu_result_valid_o[owner] = co_result_valid_i, other bit 0; co_result_ready_o = cpu_result_ready_i[owner]; cpu_result_id_o = co_result_id_i[ID_WIDTH-1:0]; data/rd/we passed through; handshake -> IDLE.
REQ-015 co_result_ready_o SHALL be 0 outside WAIT_RESULT; co_result_valid_i outside WAIT_RESULT ignored.
REQ-016 Every transition to IDLE SHALL set rr_q = ~owner.
REQ-017 Timeout counter SHALL clear on entering WAIT_RESULT, increment each WAIT_RESULT cycle without handshake, saturate; reaching TIMEOUT_CYCLES (nonzero) sets timeout_o; FSM stays in WAIT_RESULT.
REQ-018 timeout_clr_i SHALL clear timeout_o next cycle; a same-cycle set wins over clear.
REQ-019 Non-owner requests SHALL stall (ready=0) until return to IDLE; no request dropped.

Reset
REQ-020 rst_ni low at a clock edge SHALL force IDLE, rr_q=0, owner=0, wb_q=0, counter=0, timeout_o=0, abandoning any in-flight transaction.
REQ-021 During and after reset all *_valid_o, cpu_issue_ready_o, co_result_ready_o, busy_o = 0 until a new grant.

Verification
REQ-022 CPU0 issue id=3, accept=1, wb=1, commit kill=0, result data=0xDEADBEEF -> co ids 0x03, CPU0 gets result id 3, data 0xDEADBEEF, FSM IDLE after.
REQ-023 Both valid from reset -> CPU0 served first (co id MSB=0); CPU1 next (MSB=1, id 0x1x); third back-to-back grant to CPU0.
REQ-024 accept=0 on CPU1 issue -> IDLE in 1 cycle, no commit forwarded, rr_q=0.
REQ-025 accept=1, wb=1, commit kill=1 -> IDLE; later co_result_valid_i ignored, co_result_ready_o=0.
REQ-026 TIMEOUT_CYCLES=8, no result -> timeout_o=1 after 8 WAIT_RESULT cycles; pulse timeout_clr_i -> 0; late result still delivered.
REQ-027 rst_ni low in WAIT_RESULT -> next cycle IDLE, busy_o=0, timeout_o=0, all valids 0.
